// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundles the fetch-control handshake between the sequencer
// (decoder/lookup side, plus the testbench) and pc_fetch_ctrl.
//   master: drives start/stall/branch_en/taken/rel/target/halt,
//           observes prog_ctr/running/done/cycle_cnt
//   slave : the pc_fetch_ctrl side (mirror image)
interface pc_fetch_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          branch_en;
  logic          taken;
  logic          rel;
  logic [D-1:0]  target;
  logic          halt;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output start, stall, branch_en, taken, rel, target, halt,
    input  prog_ctr, running, done, cycle_cnt
  );

  modport slave (
    input  start, stall, branch_en, taken, rel, target, halt,
    output prog_ctr, running, done, cycle_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencing stage.
// Consumes the branch-target lookup output plus decoder branch/halt flags
// and produces the next fetch address. Owns the IDLE/RUN/DONE handshake and
// a saturating count of clocks spent in RUN.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high, dominates all inputs
//   bus   - pc_fetch_if slave: start, stall, branch_en, taken, rel, target,
//           halt in; prog_ctr, running, done, cycle_cnt out (all registered)
module pc_fetch_ctrl #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input logic          clk,
  input logic          reset,
  pc_fetch_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [D-1:0]  pc_q, pc_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          running_q, running_nxt;
  logic          done_q, done_nxt;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      cnt_q     <= cnt_nxt;
      running_q <= running_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next-state logic: stall outranks halt, so a stalled halt is retried
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (!bus.stall && bus.halt) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pc_nxt      = pc_q;
    cnt_nxt     = cnt_q;
    running_nxt = (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
    case (state)
      IDLE: begin
        pc_nxt = '0;
        if (bus.start) cnt_nxt = '0;
      end
      RUN: begin
        // Every RUN edge counts, stalls and the halting edge included.
        cnt_nxt = sat_inc(cnt_q);
        if (!bus.stall && !bus.halt) begin
          if (bus.branch_en && bus.taken) begin
            // A D-bit add of the two's-complement offset is the signed
            // relative jump with the carry discarded.
            pc_nxt = bus.rel ? pc_q + bus.target : bus.target;
          end else begin
            pc_nxt = pc_q + D'(1);
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          pc_nxt  = '0;
          cnt_nxt = '0;
        end
      end
      default: begin
        pc_nxt  = '0;
        cnt_nxt = '0;
      end
    endcase
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  localparam int D  = 12;
  localparam int CW = 16;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   armed    = 0;

  pc_fetch_if #(.D(D), .CW(CW)) bus ();
  pc_fetch_if #(.D(D), .CW(3))  bus3 ();

  pc_fetch_ctrl #(.D(D), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy fed with identical stimulus to reach saturation.
  pc_fetch_ctrl #(.D(D), .CW(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  assign bus3.start     = bus.start;
  assign bus3.stall     = bus.stall;
  assign bus3.branch_en = bus.branch_en;
  assign bus3.taken     = bus.taken;
  assign bus3.rel       = bus.rel;
  assign bus3.target    = bus.target;
  assign bus3.halt      = bus.halt;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=run, 2=done
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  int m_cnt3 = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_cnt3 = 0;
    end else if (m_mode == 1) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : 7;
      if (bus.stall) begin
      end else if (bus.halt) begin
        m_mode = 2;
      end else if (bus.branch_en && bus.taken) begin
        if (bus.rel) m_pc = (m_pc + int'(bus.target)) % 4096;
        else         m_pc = int'(bus.target);
      end else begin
        m_pc = (m_pc + 1) % 4096;
      end
    end else if (bus.start) begin
      m_mode = 1; m_pc = 0; m_cnt = 0; m_cnt3 = 0;
    end
  end

  // Compare every cycle, away from the rising edge
  always @(negedge clk) begin
    if (armed) begin
      chk("model_pc",      32'(bus.prog_ctr),   32'(m_pc));
      chk("model_running", 32'(bus.running),    32'(m_mode == 1));
      chk("model_done",    32'(bus.done),       32'(m_mode == 2));
      chk("model_cnt",     32'(bus.cycle_cnt),  32'(m_cnt));
      chk("model_cnt3",    32'(bus3.cycle_cnt), 32'(m_cnt3));
      chk("excl_run_done", 32'(bus.running & bus.done), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic st, input logic sl, input logic be, input logic tk,
                       input logic rl, input logic [D-1:0] tg, input logic hl);
    bus.start = st; bus.stall = sl; bus.branch_en = be; bus.taken = tk;
    bus.rel = rl; bus.target = tg; bus.halt = hl;
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, '0, 0);
    tick();
    armed = 1;
    tick();
    reset = 0;
    chk("rst_pc",      32'(bus.prog_ctr),  32'd0);
    chk("rst_running", 32'(bus.running),   32'd0);
    chk("rst_done",    32'(bus.done),      32'd0);
    chk("rst_cnt",     32'(bus.cycle_cnt), 32'd0);

    // Start and sequential fetch
    drive(1, 0, 0, 0, 0, '0, 0);
    tick();
    chk("start_running", 32'(bus.running),  32'd1);
    chk("start_pc0",     32'(bus.prog_ctr), 32'd0);
    drive(0, 0, 0, 0, 0, '0, 0);
    tick(); chk("seq_pc1", 32'(bus.prog_ctr), 32'd1);
    tick(); chk("seq_pc2", 32'(bus.prog_ctr), 32'd2);
    tick(); chk("seq_pc3", 32'(bus.prog_ctr), 32'd3);
    tick(); chk("seq_pc4", 32'(bus.prog_ctr), 32'd4);

    // Branches
    drive(0, 0, 1, 1, 1, 12'hFFF, 0);
    tick(); chk("rel_neg1", 32'(bus.prog_ctr), 32'd3);
    drive(0, 0, 1, 1, 0, 12'd37, 0);
    tick(); chk("abs_37", 32'(bus.prog_ctr), 32'd37);
    drive(0, 0, 1, 1, 1, 12'h014, 0);
    tick(); chk("rel_p20", 32'(bus.prog_ctr), 32'd57);
    drive(0, 0, 1, 0, 1, 12'h014, 0);
    tick(); chk("not_taken", 32'(bus.prog_ctr), 32'd58);
    drive(0, 0, 1, 1, 1, 12'hFFB, 0);
    tick(); chk("rel_neg5", 32'(bus.prog_ctr), 32'd53);
    drive(0, 0, 1, 1, 0, 12'd10, 0);
    tick(); chk("abs_10", 32'(bus.prog_ctr), 32'd10);
    chk("cnt_at_10", 32'(bus.cycle_cnt), 32'd10);

    // Stall beats halt and branch; start ignored in RUN
    drive(1, 1, 1, 1, 0, 12'd99, 1);
    tick(); tick();
    chk("stall_pc",      32'(bus.prog_ctr),  32'd10);
    chk("stall_running", 32'(bus.running),   32'd1);
    chk("stall_cnt",     32'(bus.cycle_cnt), 32'd12);
    drive(0, 0, 0, 0, 0, '0, 1);
    tick();
    chk("halt_done",    32'(bus.done),      32'd1);
    chk("halt_running", 32'(bus.running),   32'd0);
    chk("halt_pc",      32'(bus.prog_ctr),  32'd10);
    chk("halt_cnt",     32'(bus.cycle_cnt), 32'd13);
    chk("halt_cnt3",    32'(bus3.cycle_cnt), 32'd7);

    // Idle in DONE
    drive(0, 0, 1, 1, 0, 12'd5, 0);
    repeat (5) tick();
    chk("done_hold_pc",  32'(bus.prog_ctr),  32'd10);
    chk("done_hold_cnt", 32'(bus.cycle_cnt), 32'd13);

    // Restart
    drive(1, 0, 0, 0, 0, '0, 0);
    tick();
    chk("restart_pc",  32'(bus.prog_ctr),  32'd0);
    chk("restart_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("restart_run", 32'(bus.running),   32'd1);
    drive(0, 0, 0, 0, 0, '0, 0);
    tick();
    chk("resume_cnt", 32'(bus.cycle_cnt), 32'd1);

    // Wrap-around
    drive(0, 0, 1, 1, 0, 12'hFFE, 0);
    tick(); chk("wrap_abs", 32'(bus.prog_ctr), 32'hFFE);
    drive(0, 0, 0, 0, 0, '0, 0);
    tick(); chk("wrap_fff", 32'(bus.prog_ctr), 32'hFFF);
    tick(); chk("wrap_000", 32'(bus.prog_ctr), 32'h000);
    drive(0, 0, 1, 1, 0, 12'hFFF, 0);
    tick();
    drive(0, 0, 1, 1, 1, 12'd2, 0);
    tick(); chk("wrap_rel", 32'(bus.prog_ctr), 32'h001);
    drive(0, 0, 1, 1, 1, 12'd0, 0);
    tick(); chk("self_loop", 32'(bus.prog_ctr), 32'h001);

    // Halt, restart, run to PC=20, then reset with start
    drive(0, 0, 0, 0, 0, '0, 1);
    tick();
    drive(1, 0, 0, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, 0, 0, '0, 0);
    repeat (20) tick();
    chk("pre_rst_pc",  32'(bus.prog_ctr),  32'd20);
    chk("pre_rst_cnt", 32'(bus.cycle_cnt), 32'd20);
    reset = 1;
    drive(1, 0, 0, 0, 0, '0, 0);
    tick();
    chk("mid_rst_pc",      32'(bus.prog_ctr),  32'd0);
    chk("mid_rst_cnt",     32'(bus.cycle_cnt), 32'd0);
    chk("mid_rst_running", 32'(bus.running),   32'd0);
    chk("mid_rst_done",    32'(bus.done),      32'd0);
    reset = 0;
    drive(0, 0, 1, 1, 0, 12'd7, 1);
    tick();
    chk("idle_ignore_pc",  32'(bus.prog_ctr), 32'd0);
    chk("idle_ignore_run", 32'(bus.running),  32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing stage that sits directly downstream of the branch-target lookup table. Each cycle it consumes the 12-bit lookup output (absolute target or signed relative offset), together with the decoder's branch and halt signals, and produces the next program counter for instruction memory. It also owns the run/done handshake with the testbench and a run-cycle counter used for performance measurement.

## Interface
- D, 12, program counter width; also the width of the lookup target.
- CW, 16, cycle counter width.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  launch request; honoured only in IDLE and DONE.
- stall  in  1  hold request; freezes PC, state and halt/branch handling for the cycle.
- branch_en  in  1  the current instruction is a branch.
- taken  in  1  the branch condition evaluated true; ignored unless branch_en=1.
- rel  in  1  1 = target is a two's-complement offset added to PC; 0 = target is an absolute address.
- target  in  D  lookup output for the current branch's table index, valid in the same cycle as branch_en.
- halt  in  1  the current instruction is a halt.
- prog_ctr  out  D  current fetch address (registered).
- running  out  1  high while in RUN (registered).
- done  out  1  high while in DONE (registered).
- cycle_cnt  out  CW  number of clocks spent in RUN, stalls included (registered).

## Operation
- States: IDLE, RUN, DONE.
- Reset forces state to IDLE, prog_ctr to 0, running to 0, done to 0 and cycle_cnt to 0, regardless of any other input.
- IDLE:
  - prog_ctr is held at 0.
  - If start=1: go to RUN, clear cycle_cnt, keep prog_ctr=0 so the first fetch is address 0.
  - All other inputs are ignored.
- RUN, with priority stall > halt > taken branch > sequential:
  - If stall=1: prog_ctr, state and cycle_cnt+1 only; halt and branch are ignored this cycle.
  - Else if halt=1: go to DONE and hold prog_ctr at the halt address.
  - Else if branch_en=1 and taken=1:
    - rel=0: prog_ctr <= target.
    - rel=1: prog_ctr <= (prog_ctr + target) mod 2^D.
  - Else: prog_ctr <= (prog_ctr + 1) mod 2^D.
  - start is ignored.
- Arithmetic:
  - All PC arithmetic is D-bit unsigned with carry discarded. For example, PC=4 with offset 0xFFF (-1) gives 3; 0xFFB is -5.
  - A relative offset of 0 is a self-loop.
  - PC 0xFFF+1 wraps to 0x000.
- DONE:
  - prog_ctr and cycle_cnt hold.
  - If start=1: go to RUN, with prog_ctr <= 0 and cycle_cnt <= 0.
- cycle_cnt:
  - Increments by 1 on every clock edge where the state is RUN at the edge, including stall and halt cycles.
  - Saturates at 2^CW-1 and does not wrap.
- A branch with taken=0 behaves exactly like a sequential instruction.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Next-PC decisions use same-cycle inputs. target is combinational from the lookup and must be stable before the edge.
- Branch latency is 1 cycle: a taken branch presented while prog_ctr=P produces prog_ctr=target (or P+offset) after the next edge.
- start→running is 1 cycle. halt→done is 1 cycle, and running drops in that same cycle.
- running and done are never both 1.
- Reset asserted mid-RUN returns the block to IDLE with PC=0 on the next edge. A start asserted in that same cycle is ignored.

## Test plan
- Reset then start:
  - Before start: prog_ctr=0, running=0, done=0, cycle_cnt=0.
  - With start=1 for 1 cycle and no branches: running=1 next cycle, and prog_ctr then reads 0, 1, 2, 3 on successive cycles.
- Absolute and relative branches:
  - At PC=4, branch_en=taken=1, rel=1, target=0xFFF → PC=3.
  - At PC=3, rel=0, target=37 → PC=37.
  - At PC=37, rel=1, target=0x014 → PC=57.
  - With taken=0 at PC=57 → PC=58.
- Stall priority: at PC=10, assert stall together with halt and a taken branch for 2 cycles.
  - During the stall: PC stays 10, state stays RUN, cycle_cnt advances by 2.
  - Release stall with halt=1: done=1 next cycle and PC=10.
- Wrap-around:
  - Absolute jump to 0xFFE, then sequential → 0xFFF, 0x000.
  - Relative +2 from 0xFFF → 0x001.
- Halt and restart:
  - After done=1, hold 5 idle cycles: PC and cycle_cnt are unchanged.
  - start=1 → RUN with PC=0 and cycle_cnt=0, then counting resumes.
- Reset mid-run: at PC=20 with cycle_cnt=20, assert reset together with start → next cycle state is IDLE, PC=0, cycle_cnt=0, running=0.
